// File: rtl/aes_dispatch_pkg.sv
// Shared types and constants for the AES-128 encrypt request dispatcher.
//   disp_state_t : dispatcher FSM states
//   req_t        : one queued request {plaintext, key, tag}
//   AES_BLK_W    : AES block / key width
//   GUARD_CYCLES : cycles E_int is held low after a completion before the next launch
//   REQ_TAG_W    : tag width carried in req_t (the top's TAG_W must match it)
package aes_dispatch_pkg;
  localparam int AES_BLK_W    = 128;
  localparam int GUARD_CYCLES = 2;
  localparam int REQ_TAG_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } disp_state_t;

  typedef struct packed {
    logic [AES_BLK_W-1:0] plaintext;
    logic [AES_BLK_W-1:0] key;
    logic [REQ_TAG_W-1:0] tag;
  } req_t;
endpackage

// File: rtl/aes_req_fifo.sv
// Synchronous DEPTH-entry FIFO of req_t with full/empty/count.
//   clk, rst_n      : clock, async active-low reset (clears pointers and count)
//   push, wr_data   : write; ignored when full
//   pop, rd_data    : read; rd_data is the head entry (first-word fall-through)
//   full, empty     : occupancy flags
//   count           : occupancy, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module aes_req_fifo
  import aes_dispatch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  req_t          wr_data,
  input  logic          pop,
  output req_t          rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/aes_enc_dispatch.sv
// Request front-end for the AES-128 encrypt core.
// Queues {plaintext,key,tag} requests, launches them one at a time by holding the
// core's level start E_int with stable core_plaintext/core_key until E_done, then
// returns {ciphertext,tag} through a single-entry valid/ready result slot.
//   clk, rst_n                         : clock, async active-low reset
//   in_valid/in_ready/in_plaintext/in_key/in_tag : request port (in_ready = FIFO not full)
//   E_int, core_plaintext, core_key    : core launch interface (registered)
//   E_done, ciphertext                 : core completion pulse and its result
//   out_valid/out_ready/out_ciphertext/out_tag   : result port
//   busy                               : FSM not idle or FIFO non-empty
//   fifo_count                         : FIFO occupancy
// Optional build macro AES_DISPATCH_STATS_EN adds stat_done_cnt[31:0], a wrapping
// count of E_done captures.
module aes_enc_dispatch
  import aes_dispatch_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = REQ_TAG_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_plaintext,
  input  logic [AES_BLK_W-1:0] in_key,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 E_int,
  output logic [AES_BLK_W-1:0] core_plaintext,
  output logic [AES_BLK_W-1:0] core_key,
  input  logic                 E_done,
  input  logic [AES_BLK_W-1:0] ciphertext,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_ciphertext,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy,
  output logic [CW-1:0]        fifo_count
`ifdef AES_DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_done_cnt
`endif
);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  if (TAG_W != REQ_TAG_W) begin : g_tag_w_chk
    $error("aes_enc_dispatch: TAG_W must equal aes_dispatch_pkg::REQ_TAG_W");
  end

  req_t          wr_req, head;
  logic          full, empty;
  logic          launch, capture;
  disp_state_t   state, state_nxt;
  logic [GW-1:0] gcnt;
  logic [TAG_W-1:0] run_tag;

  assign wr_req   = '{plaintext: in_plaintext, key: in_key, tag: in_tag};
  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;

  aes_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid && in_ready),
    .wr_data (wr_req),
    .pop     (launch),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Launch waits for an empty result slot so back-pressure never reaches the core.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE:  if (!empty && !out_valid) begin
               launch    = 1'b1;
               state_nxt = RUN;
             end
      RUN:   if (E_done) begin
               capture   = 1'b1;
               state_nxt = GUARD;
             end
      GUARD: if (gcnt == GW'(GUARD_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      E_int <= 1'b0;
      gcnt  <= '0;
    end else begin
      state <= state_nxt;
      E_int <= (state_nxt == RUN);
      gcnt  <= (state == GUARD) ? gcnt + GW'(1) : '0;
    end
  end

  // Launch registers: only written on launch, so in_* changes never reach the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_plaintext <= '0;
      core_key       <= '0;
      run_tag        <= '0;
    end else if (launch) begin
      core_plaintext <= head.plaintext;
      core_key       <= head.key;
      run_tag        <= head.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_ciphertext <= '0;
      out_tag        <= '0;
    end else if (capture) begin
      out_valid      <= 1'b1;
      out_ciphertext <= ciphertext;
      out_tag        <= run_tag;
    end else if (out_valid && out_ready) begin
      out_valid      <= 1'b0;
    end
  end

`ifdef AES_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stat_done_cnt <= '0;
    else if (capture) stat_done_cnt <= stat_done_cnt + 32'd1;
  end
`endif
endmodule
